// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: instruction encodings, reset PC and fetch FSM states.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_next_pc.sv
// Next-PC selector: jump beats branch, both beat sequential increment; otherwise hold.
module if_next_pc (
  input  logic [31:0] i_pc,
  input  logic        i_redirect_en,
  input  logic        i_incr,
  input  logic        i_jump_taken,
  input  logic [31:0] i_jump_target,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic        o_redirect,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_pc_plus4;
  logic        w_redirect;

  assign w_pc_plus4 = i_pc + 32'd4;
  assign w_redirect = i_redirect_en & (i_jump_taken | i_branch_taken);
  assign o_pc_plus4 = w_pc_plus4;
  assign o_redirect = w_redirect;

  always_comb begin
    o_next_pc = i_pc;
    if (w_redirect) begin
      o_next_pc = i_jump_taken ? i_jump_target : i_branch_target;
    end else if (i_incr) begin
      o_next_pc = w_pc_plus4;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC generation, imem addressing and the IF/ID register write side.
// States: IDLE waits for start, RUN fetches every cycle, STEP fetches per step rising edge, HALTED waits for reset.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF,
  parameter logic [31:0] NOP_WORD  = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        step_mode,
  input  logic        step,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr_out,
  output logic [31:0] pc4_out,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic        halted
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, r_instr, r_pc4;
  logic         r_valid, r_step_d;

  logic         w_active, w_step_rise, w_redirect, w_advance, w_is_halt, w_incr;
  logic         w_flush, w_halted;
  logic [31:0]  w_next_pc, w_pc_plus4;

  assign w_active    = (r_state == RUN) || (r_state == STEP);
  assign w_step_rise = step & ~r_step_d;
  assign w_flush     = flush & ~w_redirect;
  assign w_advance   = w_active & ~w_redirect & ~flush & ~stall &
                       ((r_state == RUN) | w_step_rise);
  // A fetched halt word is still delivered to ID, but the PC stays on it.
  assign w_is_halt   = w_advance & (imem_data == HALT_WORD);
  assign w_incr      = w_advance & ~w_is_halt;

  if_next_pc u_next_pc (
    .i_pc            (r_pc),
    .i_redirect_en   (w_active),
    .i_incr          (w_incr),
    .i_jump_taken    (jump_taken),
    .i_jump_target   (jump_target),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .o_redirect      (w_redirect),
    .o_pc_plus4      (w_pc_plus4),
    .o_next_pc       (w_next_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (start) w_state_nxt = step_mode ? STEP : RUN;
      RUN, STEP: if (w_is_halt) w_state_nxt = HALTED;
      default:   w_state_nxt = r_state;
    endcase
  end

  always_comb begin
    w_halted = (r_state == HALTED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_instr  <= NOP_WORD;
      r_pc4    <= 32'd0;
      r_valid  <= 1'b0;
      r_step_d <= 1'b0;
    end else begin
      r_step_d <= step;
      r_pc     <= w_next_pc;
      if (w_halted || (w_active && (w_redirect || w_flush))) begin
        r_instr <= NOP_WORD;
        r_valid <= 1'b0;
      end else if (w_advance) begin
        r_instr <= imem_data;
        r_pc4   <= w_pc_plus4;
        r_valid <= 1'b1;
      end
    end
  end

  assign imem_addr = r_pc;
  assign pc_out    = r_pc;
  assign instr_out = r_instr;
  assign pc4_out   = r_pc4;
  assign valid_out = r_valid;
  assign halted    = w_halted;

endmodule
